// File: rtl/riscv_mem_pkg.sv
// Shared load/store definitions for the data-memory responder: funct3 codes,
// FSM encoding and the access legality check.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Range test uses the full word address, so aliasing above the array faults.
  function automatic logic access_fault(input logic        we,
                                        input logic [2:0]  funct3,
                                        input logic [31:0] addr,
                                        input logic [31:0] depth_words);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = we;
      F3_H:    bad = addr[0];
      F3_HU:   bad = we | addr[0];
      F3_W:    bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= depth_words) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// RV32 lane formatting: store data to byte lanes plus byte enables, and
// load word to extracted, sign/zero-extended result.
module lsu_lane_fmt
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Replicating the source across lanes lets the byte enables pick the slot.
  always_comb begin
    byte_en     = 4'b0000;
    store_lanes = store_data;
    case (funct3[1:0])
      2'b00: begin
        byte_en     = 4'b0001 << byte_off;
        store_lanes = {4{store_data[7:0]}};
      end
      2'b01: begin
        byte_en     = byte_off[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{store_data[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  assign sel_byte = load_word[{byte_off, 3'b000} +: 8];
  assign sel_half = byte_off[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data = {24'h000000, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data = {16'h0000, sel_half};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target for the MEM stage: stalls the pipeline for
// LATENCY wait cycles, then answers with formatted load data or a fault.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall_o,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          we_q;
  logic [2:0]    funct3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          fault;
  logic [3:0]    byte_en;
  logic [31:0]   store_lanes;
  logic [31:0]   word_rd;
  logic [31:0]   load_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          cnt   <= 4'(LATENCY);
          state <= (LATENCY > 0) ? WAIT : RESP;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request fields are latched once at accept; later changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
  end

  assign idx     = addr_q[AW+1:2];
  assign word_rd = mem[idx];
  assign fault   = access_fault(we_q, funct3_q, addr_q, 32'(DEPTH_WORDS));

  lsu_lane_fmt u_fmt (
    .funct3      (funct3_q),
    .byte_off    (addr_q[1:0]),
    .store_data  (wdata_q),
    .load_word   (word_rd),
    .byte_en     (byte_en),
    .store_lanes (store_lanes),
    .load_data   (load_data)
  );

  // Commit at the end of RESP only, so any load issued later sees this store.
  always_ff @(posedge clk) begin
    if (state == RESP && we_q && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= store_lanes[8*b +: 8];
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid & fault;
  assign rsp_rdata = (rsp_valid && !fault && !we_q) ? load_data : 32'h0;
  assign stall_o   = req_valid & (state != RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder at LATENCY=2 and LATENCY=0
// against a byte-addressed reference model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        vld_a, vld_b;
  logic        stall_a, stall_b, rv_a, rv_b, err_a, err_b;
  logic [31:0] rd_a, rd_b;
  logic        stall;

  always #5 clk = ~clk;

  assign vld_a = req_valid & ~sel;
  assign vld_b = req_valid & sel;
  assign stall = sel ? stall_b : stall_a;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid(vld_a), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall_o(stall_a), .rsp_valid(rv_a),
    .rsp_rdata(rd_a), .rsp_err(err_a));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(vld_b), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall_o(stall_b), .rsp_valid(rv_b),
    .rsp_rdata(rd_b), .rsp_err(err_b));

  typedef struct {
    bit          s;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t       sbq[$];
  bit [7:0]   mb[2][256];
  int         lat[2] = '{2, 0};
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: memory as bytes, access size from funct3, extension by arithmetic.
  task automatic model(input bit s, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output bit err);
    int     size;
    bit     uns;
    longint v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    uns   = f3[2];
    err   = 1'b0;
    rdata = 32'h0;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) err = 1'b1;
    if (addr % size != 0) err = 1'b1;
    if (we && uns) err = 1'b1;
    if (addr / 4 >= DEPTH) err = 1'b1;
    if (err) return;
    if (we) begin
      for (int i = 0; i < size; i++) mb[s][(int'(addr) + i) % 256] = 8'((wdata >> (8 * i)) & 32'hFF);
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v = v | (longint'(mb[s][(int'(addr) + i) % 256]) << (8 * i));
      if (!uns && size < 4 && ((v >> (8 * size - 1)) & 1) == 1) v = v - (longint'(1) << (8 * size));
      rdata = v[31:0];
    end
  endtask

  // Called at a negedge while the target is idle; returns at the next idle negedge.
  task automatic do_req(input bit s, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] er;
    bit          ee;
    int          stalls;
    int          budget;
    sel = s; req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    model(s, we, f3, addr, wdata, er, ee);
    sbq.push_back('{s, er, ee, cyc + lat[s] + 1});
    #1;
    stalls = stall ? 1 : 0;
    budget = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
      budget++;
      if (budget > 40) begin
        n_chk++; n_fail++;
        $display("FAIL req_timeout: stall still high after %0d cycles, expected %0d", budget, lat[s] + 1);
        break;
      end
    end
    chk("stall_cycles", 32'(stalls), 32'(lat[s] + 1));
    @(negedge clk);
  endtask

  task automatic idle_gap(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("idle_stall_a", {31'b0, stall_a}, 32'h0);
      chk("idle_stall_b", {31'b0, stall_b}, 32'h0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rv_a || rv_b) begin
      if (sbq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid a=%0b b=%0b with no pending access, expected none", rv_a, rv_b);
      end else begin
        e = sbq.pop_front();
        chk("rsp_port", {31'b0, rv_b}, {31'b0, e.s});
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        chk("rsp_rdata", rv_b ? rd_b : rd_a, e.rdata);
        chk("rsp_err", {31'b0, rv_b ? err_b : err_a}, {31'b0, e.err});
      end
    end
  end

  initial begin
    logic [31:0] old_rd;
    bit          old_err;
    rst = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", {30'b0, rv_a, rv_b}, 32'h0);
    chk("reset_rdata_a", rd_a, 32'h0);
    chk("reset_err", {30'b0, err_a, err_b}, 32'h0);
    chk("reset_stall", {30'b0, stall_a, stall_b}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 64; w++) do_req(s[0], 1'b1, LW, 32'(w * 4), $urandom);

    do_req(0, 1, LW, 32'h10, 32'hDEADBEEF);
    do_req(0, 0, LW, 32'h10, 32'h0);
    do_req(0, 1, LB, 32'h13, 32'h80);
    do_req(0, 0, LW, 32'h10, 32'h0);
    do_req(0, 0, LB, 32'h13, 32'h0);
    do_req(0, 0, LBU, 32'h13, 32'h0);
    do_req(0, 1, LH, 32'h12, 32'h1234);
    do_req(0, 0, LW, 32'h10, 32'h0);
    do_req(0, 0, LH, 32'h11, 32'h0);
    do_req(0, 0, LW, 32'h10, 32'h0);
    do_req(0, 1, LW, 32'(4 * DEPTH), 32'h55AA55AA);
    do_req(0, 0, 3'b011, 32'h10, 32'h0);
    do_req(0, 0, LW, 32'h0, 32'h0);
    idle_gap(2);

    do_req(1, 0, LW, 32'h10, 32'h0);
    do_req(1, 0, LW, 32'h14, 32'h0);
    do_req(1, 1, LHU, 32'h22, 32'hFFFF);
    do_req(1, 0, LHU, 32'h22, 32'h0);
    do_req(1, 0, LH, 32'h22, 32'h0);
    idle_gap(2);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? 32'(4 * DEPTH) + $urandom_range(0, 63) : $urandom_range(0, 255);
      do_req($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), a, $urandom);
      if ($urandom_range(0, 9) == 0) idle_gap($urandom_range(1, 3));
    end

    model(0, 0, LW, 32'h20, 32'h0, old_rd, old_err);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_funct3 = LW;
    req_addr = 32'h20; req_wdata = ~old_rd;
    @(negedge clk);
    #1 rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'b0, rv_a}, 32'h0);
    chk("midrst_rdata", rd_a, 32'h0);
    chk("midrst_err", {31'b0, err_a}, 32'h0);
    chk("midrst_stall", {31'b0, stall_a}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    do_req(0, 0, LW, 32'h20, 32'h0);
    idle_gap(3);

    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory target that answers the MEM stage's load/store requests.
- Holds the MEM stage with a stall line until the access completes, so the pipeline tolerates variable memory latency.
- Performs RV32 byte/half/word lane formatting and load sign/zero extension internally.
- Flags misaligned, illegal-funct3 and out-of-range accesses instead of touching storage.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit storage words; the word index is addr[log2(DEPTH_WORDS)+1:2].
- LATENCY, 2, wait cycles between accept and response (legal 0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  MEM stage has an access (MemRead | MemWrite).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 load/store funct3.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data, right-aligned.
- stall_o  out  1  hold PC/IFID/IDEX/EXMEM/MEMWB.
- rsp_valid  out  1  one-cycle pulse; access complete.
- rsp_rdata  out  32  formatted load data; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid; access faulted.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req_valid=1: capture we, funct3, addr and wdata; load counter=LATENCY.
  - Go to WAIT if LATENCY>0, else go to RESP.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to RESP.
- RESP:
  - rsp_valid=1 for exactly this cycle.
  - A store's write commits at the end of this cycle.
  - Load data is read from storage in this cycle. Storage is asynchronous-read and is written only at the end of RESP, so a load always sees all prior stores.
  - Next state is always IDLE.
- Response timing: a request accepted at cycle T produces rsp_valid at cycle T+LATENCY+1.
- stall_o = req_valid & (state != RESP), combinational. It is low in RESP so the pipeline advances on that edge.
- Back-to-back requests: in the IDLE cycle after RESP, the next request is seen and accepted. There is no bypass and no accept while in RESP.
- The requester holds all req_* stable while stall_o=1. Captured values are used in any case; changes during WAIT are ignored.
- Lane rules:
  - SB (000): write byte lane addr[1:0].
  - SH (001): write half lane addr[1].
  - SW (010): write all lanes.
  - LB (000) / LH (001): sign-extend the selected byte/half.
  - LBU (100) / LHU (101): zero-extend the selected byte/half.
  - LW (010): full word.
- Errors, checked on the captured request; each forces rsp_err=1, rsp_rdata=0 and no write:
  - funct3 in {011, 110, 111};
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - store with funct3 100/101;
  - word index >= DEPTH_WORDS.
- Errored accesses still follow the full LATENCY timing.
- Reset mid-operation: return to IDLE, no write, no response. A pending store is dropped.
- req_valid=0 in IDLE: stay in IDLE, stall_o=0.

Decomposition:
- Shared package riscv_mem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - a misalignment/illegal-check function.
- One sub-module, lsu_lane_fmt (combinational):
  - store path: wdata → 4-bit byte-enable + lane-shifted data;
  - load path: word → extracted/extended data.
- FSM, counter and storage array stay in dmem_responder.

Test Plan:
- LATENCY=2: SW 0xDEADBEEF @0x10, then LW @0x10. Required: rsp_valid at T+3 for each; stall_o high for 3 cycles per access; load returns 0xDEADBEEF, rsp_err=0.
- SB 0x80 @0x13, then LB @0x13 and LBU @0x13. Required: word 0x10 reads 0x80ADBEEF; LB → 0xFFFFFF80, LBU → 0x00000080.
- SH 0x1234 @0x12, then LH @0x11. Required: SH writes the upper half (word=0x1234BEEF); LH @0x11 → rsp_err=1, rdata=0, storage unchanged.
- SW @ byte address 4*DEPTH_WORDS, and LW with funct3=011. Required: both give rsp_err=1 with correct latency and no write.
- LATENCY=0: back-to-back LW, LW. Required: rsp_valid on the cycle after each accept; one idle cycle between responses.
- rst pulsed low during WAIT of a SW. Required: outputs clear immediately, no rsp_valid, target word retains its old value.
